// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: resets the PLL, waits for a stable lock, retries up to a
// limit, then releases downstream reset and services single phase-step requests.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned SETTLE_CYCLES       = 64
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       ps_req,
  input  logic       ps_dir,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic       ps_ack,
  output logic       sys_rst,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_PSTEP     = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_B   = (LOCK_STABLE_CYCLES > SETTLE_CYCLES) ? LOCK_STABLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_q, retry_d;
  logic [3:0]    psda_q, psda_d;
  logic [3:0]    dutyda_q, dutyda_d;
  logic          sync1_q, sync2_q;
  logic          pll_reset_q, pll_reset_d;
  logic          sys_rst_q, sys_rst_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic          ps_ack_q, ps_ack_d;
  logic          lock_s;
  logic [3:0]    retry_inc_s;
  logic [3:0]    step_psda_s;

  assign lock_s      = sync2_q;
  assign retry_inc_s = {1'b0, retry_q} + 4'd1;
  assign step_psda_s = ps_dir ? (psda_q + 4'd1) : (psda_q - 4'd1);

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      retry_q     <= 3'd0;
      psda_q      <= 4'h0;
      dutyda_q    <= 4'h8;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      ps_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      psda_q      <= psda_d;
      dutyda_q    <= dutyda_d;
      sync1_q     <= pll_lock;
      sync2_q     <= sync1_q;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      ps_ack_q    <= ps_ack_d;
    end
  end

  // Next-state, counter, retry and phase-select logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    psda_d   = psda_q;
    dutyda_d = dutyda_q;
    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // The cycle that first sees lock counts toward the stable window.
        if (lock_s) begin
          cnt_d = CNT_ONE;
          if (LOCK_STABLE_CYCLES <= 1) begin
            state_d = ST_RUN;
            retry_d = 3'd0;
          end else begin
            state_d = ST_STABLE;
          end
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          retry_d = (retry_inc_s > 4'd7) ? 3'd7 : retry_inc_s[2:0];
          if (32'(retry_inc_s) > MAX_RETRIES) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RST;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_RST;
          cnt_d   = '0;
        end else if (ps_req) begin
          state_d  = ST_PSTEP;
          cnt_d    = '0;
          psda_d   = step_psda_s;
          dutyda_d = step_psda_s + 4'd8;
        end else begin
          cnt_d = '0;
        end
      end
      ST_PSTEP: begin
        if (!lock_s) begin
          state_d = ST_RST;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is registered
  always_comb begin
    pll_reset_d = (state_d == ST_RST) || (state_d == ST_FAIL);
    sys_rst_d   = !((state_d == ST_RUN) || (state_d == ST_PSTEP));
    locked_d    = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    ps_ack_d    = (state_q == ST_PSTEP) && (state_d == ST_RUN);
  end

  assign pll_reset = pll_reset_q;
  assign psda      = psda_q;
  assign dutyda    = dutyda_q;
  assign ps_ack    = ps_ack_q;
  assign sys_rst   = sys_rst_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters; expected
// values are hand-derived cycle counts relative to the sampling edge.
module tb_pll_lock_sequencer;

  logic       clkin;
  logic       reset;
  logic       pll_lock;
  logic       ps_req;
  logic       ps_dir;
  logic       pll_reset;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic       ps_ack;
  logic       sys_rst;
  logic       locked;
  logic       fail;
  logic [2:0] retry_cnt;

  int vectors;
  int miscompares;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .SETTLE_CYCLES       (3)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .ps_req    (ps_req),
    .ps_dir    (ps_dir),
    .pll_reset (pll_reset),
    .psda      (psda),
    .dutyda    (dutyda),
    .ps_ack    (ps_ack),
    .sys_rst   (sys_rst),
    .locked    (locked),
    .fail      (fail),
    .retry_cnt (retry_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    pll_lock = 1'b0;
    ps_req   = 1'b0;
    ps_dir   = 1'b0;

    tick(3);
    chk("rst_pll_reset", 8'(pll_reset), 8'd1);
    chk("rst_sys_rst",   8'(sys_rst),   8'd1);
    chk("rst_psda",      8'(psda),      8'h0);
    chk("rst_dutyda",    8'(dutyda),    8'h8);
    chk("rst_ps_ack",    8'(ps_ack),    8'd0);
    chk("rst_locked",    8'(locked),    8'd0);
    chk("rst_fail",      8'(fail),      8'd0);
    chk("rst_retry",     8'(retry_cnt), 8'd0);

    // Clean lock: pll_reset high for 4 cycles, lock pin raised 10 cycles after release
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("rst_hold", 8'(pll_reset), 8'(i < 4));
    end
    tick(6);
    pll_lock = 1'b1;
    tick(9);
    chk("lock_early_locked",  8'(locked),  8'd0);
    chk("lock_early_sys_rst", 8'(sys_rst), 8'd1);
    tick(1);
    chk("lock_locked",    8'(locked),    8'd1);
    chk("lock_sys_rst",   8'(sys_rst),   8'd0);
    chk("lock_pll_reset", 8'(pll_reset), 8'd0);
    chk("lock_retry",     8'(retry_cnt), 8'd0);

    // Phase wrap downward, with a request during PSTEP that must be ignored
    ps_req = 1'b1;
    ps_dir = 1'b0;
    tick(1);
    chk("dn_psda",   8'(psda),   8'hF);
    chk("dn_dutyda", 8'(dutyda), 8'h7);
    chk("dn_locked", 8'(locked), 8'd0);
    chk("dn_ack0",   8'(ps_ack), 8'd0);
    ps_dir = 1'b1;
    tick(1);
    chk("pstep_ignore_psda", 8'(psda), 8'hF);
    tick(1);
    ps_req = 1'b0;
    chk("dn_ack_early", 8'(ps_ack), 8'd0);
    tick(1);
    chk("dn_ack",    8'(ps_ack), 8'd1);
    chk("dn_run",    8'(locked), 8'd1);
    chk("dn_psda_k", 8'(psda),   8'hF);

    // Phase wrap upward
    ps_req = 1'b1;
    ps_dir = 1'b1;
    tick(1);
    ps_req = 1'b0;
    chk("up_ack_clear", 8'(ps_ack), 8'd0);
    chk("up_psda",      8'(psda),   8'h0);
    chk("up_dutyda",    8'(dutyda), 8'h8);
    tick(2);
    chk("up_ack_early", 8'(ps_ack), 8'd0);
    tick(1);
    chk("up_ack", 8'(ps_ack), 8'd1);
    tick(1);

    // Lock loss coincides with a step request at the FSM: loss wins
    pll_lock = 1'b0;
    tick(2);
    chk("ll_still_run", 8'(locked), 8'd1);
    ps_req = 1'b1;
    ps_dir = 1'b1;
    tick(1);
    ps_req   = 1'b0;
    pll_lock = 1'b1;
    chk("ll_psda",      8'(psda),      8'h0);
    chk("ll_dutyda",    8'(dutyda),    8'h8);
    chk("ll_sys_rst",   8'(sys_rst),   8'd1);
    chk("ll_pll_reset", 8'(pll_reset), 8'd1);
    chk("ll_locked",    8'(locked),    8'd0);
    chk("ll_retry",     8'(retry_cnt), 8'd0);
    tick(1);
    chk("ll_no_ack", 8'(ps_ack), 8'd0);

    // Relock with a one-cycle glitch at stable count 5
    tick(6);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(4);
    chk("glitch_restart", 8'(locked), 8'd0);
    tick(5);
    chk("glitch_early", 8'(locked), 8'd0);
    tick(1);
    chk("glitch_locked", 8'(locked), 8'd1);
    chk("relock_psda",   8'(psda),   8'h0);
    chk("relock_dutyda", 8'(dutyda), 8'h8);

    // Reset one cycle after a step
    ps_req = 1'b1;
    ps_dir = 1'b1;
    tick(1);
    ps_req = 1'b0;
    chk("mid_psda",   8'(psda),   8'h1);
    chk("mid_dutyda", 8'(dutyda), 8'h9);
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    chk("mid_rst_psda",      8'(psda),      8'h0);
    chk("mid_rst_dutyda",    8'(dutyda),    8'h8);
    chk("mid_rst_pll_reset", 8'(pll_reset), 8'd1);
    chk("mid_rst_sys_rst",   8'(sys_rst),   8'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_ack", 8'(ps_ack), 8'd0);
      tick(1);
    end

    // Timeout: three failed attempts, then terminal FAIL
    reset = 1'b0;
    tick(35);
    chk("to1_retry_pre", 8'(retry_cnt), 8'd0);
    chk("to1_pll_reset", 8'(pll_reset), 8'd0);
    tick(1);
    chk("to1_retry",     8'(retry_cnt), 8'd1);
    chk("to1_rst_again", 8'(pll_reset), 8'd1);
    tick(35);
    chk("to2_retry_pre", 8'(retry_cnt), 8'd1);
    tick(1);
    chk("to2_retry", 8'(retry_cnt), 8'd2);
    tick(35);
    chk("to3_fail_pre", 8'(fail),      8'd0);
    chk("to3_retry_pre", 8'(retry_cnt), 8'd2);
    tick(1);
    chk("to3_fail",      8'(fail),      8'd1);
    chk("to3_retry",     8'(retry_cnt), 8'd3);
    chk("to3_pll_reset", 8'(pll_reset), 8'd1);
    chk("to3_sys_rst",   8'(sys_rst),   8'd1);
    chk("to3_locked",    8'(locked),    8'd0);
    pll_lock = 1'b1;
    ps_req   = 1'b1;
    tick(20);
    ps_req = 1'b0;
    chk("fail_sticky",        8'(fail),   8'd1);
    chk("fail_sticky_locked", 8'(locked), 8'd0);
    chk("fail_sticky_psda",   8'(psda),   8'h0);
    reset = 1'b1;
    tick(1);
    chk("fail_cleared", 8'(fail),      8'd0);
    chk("retry_cleared", 8'(retry_cnt), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_reset is held high per attempt.
REQ-002 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, maximum cycles to wait for lock per attempt.
REQ-003 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synced-lock-high cycles required before release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 7, failed attempts allowed before FAIL.
REQ-005 The block SHALL have parameter SETTLE_CYCLES, default 64, wait after a phase step before acknowledging it.
REQ-006 The block SHALL have port clkin  in  1  free-running reference clock; the only clock.
REQ-007 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 The block SHALL have port pll_lock  in  1  PLL LOCK output, asynchronous to clkin.
REQ-009 The block SHALL have port ps_req  in  1  phase-step request, sampled each cycle.
REQ-010 The block SHALL have port ps_dir  in  1  step direction: 1 = +1, 0 = -1; valid with ps_req.
REQ-011 The block SHALL have port pll_reset  out  1  drives the PLL RESET input.
REQ-012 The block SHALL have port psda  out  4  drives the PLL PSDA phase-select input.
REQ-013 The block SHALL have port dutyda  out  4  drives the PLL DUTYDA input.
REQ-014 The block SHALL have port ps_ack  out  1  one-cycle pulse when a phase step has settled.
REQ-015 The block SHALL have port sys_rst  out  1  active-high reset for downstream logic on the PLL clock domain.
REQ-016 The block SHALL have port locked  out  1  high only in RUN.
REQ-017 The block SHALL have port fail  out  1  high only in FAIL.
REQ-018 The block SHALL have port retry_cnt  out  3  failed attempts so far, saturating at 7.

Function
REQ-019 pll_lock SHALL pass through a 2-flop synchronizer; "lock" below means the synchronized value, lagging the pin by 2 cycles.
REQ-020 The FSM SHALL have states RST, WAIT_LOCK, STABLE, RUN, PSTEP and FAIL.
REQ-021 RST SHALL hold pll_reset=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-022 WAIT_LOCK SHALL go to STABLE when lock=1, and SHALL declare the attempt failed after LOCK_TIMEOUT_CYCLES cycles with lock=0.
REQ-023 STABLE SHALL go to RUN after LOCK_STABLE_CYCLES consecutive cycles with lock=1; any lock=0 cycle SHALL return it to WAIT_LOCK with the timeout counter restarted.
REQ-024 On a failed attempt, retry_cnt SHALL increment; if the new value is greater than MAX_RETRIES, the FSM SHALL go to FAIL, otherwise to RST.
REQ-025 FAIL SHALL be terminal until reset; in FAIL, pll_reset=1 and sys_rst=1.
REQ-026 sys_rst SHALL be 0 only in RUN and PSTEP, and pll_reset SHALL be 1 only in RST and FAIL (both registered).
REQ-027 A lock=0 cycle in RUN or PSTEP SHALL cause the next cycle to be RST with sys_rst=1 and locked=0; it does not count as a failed attempt.
REQ-028 On entering RUN, retry_cnt SHALL clear to 0.
REQ-029 ps_req=1 in RUN SHALL update psda to psda±1 mod 16 (0xF+1=0x0, 0x0-1=0xF) and dutyda to (new psda + 8) mod 16 on the next edge, then enter PSTEP.
REQ-030 PSTEP SHALL wait SETTLE_CYCLES cycles, pulse ps_ack for 1 cycle, and return to RUN.
REQ-031 ps_req SHALL be ignored outside RUN, including during PSTEP; no ack is issued for an ignored request.
REQ-032 If lock=0 and ps_req=1 arrive in the same RUN cycle, lock loss SHALL win: psda is unchanged and no ack is issued.
REQ-033 Lock loss during PSTEP SHALL abort the step and issue no ps_ack; psda/dutyda keep their stepped values.
REQ-034 psda and dutyda SHALL be retained across relock and cleared only by reset.

Reset
REQ-035 While reset=1, the block SHALL hold state RST with counters cleared.
REQ-036 Outputs during reset SHALL be: pll_reset=1, sys_rst=1, psda=0x0, dutyda=0x8, ps_ack=0, locked=0, fail=0, retry_cnt=0, synchronizer=0.
REQ-037 Reset SHALL take effect on the next edge from any state, including mid-phase-step.
REQ-038 After reset is released, the PLL_RST_CYCLES count SHALL start on the first cycle with reset=0.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SETTLE_CYCLES=3)
REQ-039 Clean lock: release reset, raise pll_lock 10 cycles later -> pll_reset high 4 cycles; locked=1 and sys_rst=0 at 2+8 cycles after pll_lock rises; retry_cnt=0.
REQ-040 Timeout: hold pll_lock=0 -> three RST/WAIT_LOCK attempts; retry_cnt goes 1, 2, 3; fail=1 after the third timeout; stays there until reset.
REQ-041 Glitch in STABLE: drop pll_lock for 1 cycle at stable count 5 -> STABLE restarts; locked rises 8 synced-high cycles after recovery.
REQ-042 Phase wrap: in RUN, ps_req with ps_dir=0 -> psda=0xF, dutyda=0x7, ps_ack 3 cycles later; then ps_dir=1 -> psda=0x0, dutyda=0x8.
REQ-043 Lock loss versus step: in RUN, drop pll_lock aligned so synced lock=0 coincides with ps_req -> psda unchanged, no ps_ack, sys_rst=1, pll_reset=1 next cycle; relock yields locked=1 with psda unchanged.
REQ-044 Reset mid-PSTEP: assert reset 1 cycle after a step -> psda=0x0, dutyda=0x8, no ps_ack, pll_reset=1.
